// File: rtl/vedic_mult_seq.sv
// vedic_mult_seq: multi-cycle Urdhva-Tiryagbhyam multiplier.
// Consumes the multiplier two bits per cycle (LSB digit first). Each digit row
// is built from WIDTH/2 2x2 Vedic cells, then shifted into a 2*WIDTH
// accumulator. Signed mode works on magnitudes and negates the final sum.
module vedic_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam int RW     = WIDTH + 2;
  localparam int PW     = 2 * WIDTH;

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("vedic_mult_seq: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic            r_neg;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_acc;
  logic [PW-1:0]   r_p;

  logic            w_accept;
  logic            w_last;
  logic [1:0]      w_digit;
  logic [RW-1:0]   w_row;
  logic [PW-1:0]   w_sum;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  // 2x2 Vedic cell: vertical/crosswise partial products through half adders.
  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic q0, t1, t2, s1, h1, q3, s2, s3;
    q0 = x[0] & y[0];
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    s1 = t1 ^ t2;
    h1 = t1 & t2;
    q3 = x[1] & y[1];
    s2 = q3 ^ h1;
    s3 = q3 & h1;
    return {s3, s2, s1, q0};
  endfunction

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), still fits unsigned.
  assign w_mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign w_mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign w_digit = r_mag_b[1:0];
  assign w_last  = (r_cnt == CW'(DIGITS - 1));
  assign w_sum   = r_acc + (PW'(w_row) << {r_cnt, 1'b0});
  assign p       = r_p;

  // Digit row: one 2x2 cell per multiplicand digit, summed at 2-bit offsets.
  always_comb begin
    w_row = '0;
    for (int k = 0; k < DIGITS; k++) begin
      w_row = w_row + (RW'(vedic2x2(r_mag_a[2*k +: 2], w_digit)) << (2 * k));
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          w_next   = in_valid ? S_BUSY : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Nothing is accepted while reset is held.
    if (rst) in_ready = 1'b0;
  end

  assign w_accept = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Operand capture, digit accumulation and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg   <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      r_cnt   <= '0;
      r_acc   <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc   <= w_sum;
      r_mag_b <= r_mag_b >> 2;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) r_p <= r_neg ? -w_sum : w_sum;
    end
  end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Testbench for vedic_mult_seq: WIDTH=8 table, back-to-back, backpressure and
// reset sequences, plus an exhaustive WIDTH=4 sweep, all through a scoreboard.
module tb_vedic_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        in_valid4, in_ready4, sm4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;

  vedic_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .p(p8), .busy(busy8)
  );

  vedic_mult_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
    .out_ready(out_ready4), .p(p4), .busy(busy4)
  );

  typedef struct { logic [15:0] exp; int cyc; } sb_t;
  typedef struct { logic [7:0] a; logic [7:0] b; logic sm; logic [15:0] exp; } vec_t;

  sb_t  q8[$];
  sb_t  q4[$];
  vec_t vecs[11];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_next8;
  bit          acc8, acc4, lat8_done, lat4_done;
  int          acc_cyc8, n_acc8;

  // Reference product of two w-bit operands, truncated to 2w bits.
  function automatic logic [15:0] ref_mul(int w, logic [7:0] x, logic [7:0] y, logic sm);
    int xi, yi;
    logic [31:0] r;
    xi = int'(x);
    yi = int'(y);
    if (sm && x[w-1]) xi = xi - (1 << w);
    if (sm && y[w-1]) yi = yi - (1 << w);
    r = xi * yi;
    return r[15:0] & 16'((32'd1 << (2 * w)) - 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: actual=no response required=response (t=%0t)", name, $time);
  endtask

  // Scoreboard: push on handshake, check latency at first sight of out_valid,
  // pop and compare on hand-off.
  task automatic mon();
    sb_t e;
    if (out_valid8) begin
      if (q8.size() == 0) fail_now("sb8_unexpected_result");
      else begin
        if (!lat8_done) begin chk("lat8", cyc - q8[0].cyc, 5); lat8_done = 1; end
        if (out_ready8) begin
          e = q8.pop_front();
          chk("p8", 32'(p8), 32'(e.exp));
          lat8_done = 0;
        end
      end
    end
    if (in_valid8 && in_ready8) begin
      e.exp = exp_next8; e.cyc = cyc;
      q8.push_back(e);
      acc8 = 1; n_acc8++; acc_cyc8 = cyc;
    end
    if (out_valid4) begin
      if (q4.size() == 0) fail_now("sb4_unexpected_result");
      else begin
        if (!lat4_done) begin chk("lat4", cyc - q4[0].cyc, 3); lat4_done = 1; end
        if (out_ready4) begin
          e = q4.pop_front();
          chk("p4", 32'(p4), 32'(e.exp));
          lat4_done = 0;
        end
      end
    end
    if (in_valid4 && in_ready4) begin
      e.exp = ref_mul(4, {4'b0, a4}, {4'b0, b4}, sm4); e.cyc = cyc;
      q4.push_back(e);
      acc4 = 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc8();
    int n = 0;
    acc8 = 0;
    do begin tick(); n++; end while (!acc8 && n < 20);
    if (!acc8) fail_now("accept8_timeout");
  endtask

  task automatic wait_acc4();
    int n = 0;
    acc4 = 0;
    do begin tick(); n++; end while (!acc4 && n < 20);
    if (!acc4) fail_now("accept4_timeout");
  endtask

  task automatic drain8();
    int n = 0;
    while (q8.size() != 0 && n < 30) begin tick(); n++; end
    if (q8.size() != 0) fail_now("drain8_timeout");
  endtask

  task automatic drain4();
    int n = 0;
    while (q4.size() != 0 && n < 30) begin tick(); n++; end
    if (q4.size() != 0) fail_now("drain4_timeout");
  endtask

  task automatic set8(logic [7:0] x, logic [7:0] y, logic sm, logic [15:0] e);
    a8 = x; b8 = y; sm8 = sm; exp_next8 = e;
  endtask

  initial begin
    int c0, na, n;
    rst = 1'b1;
    in_valid8 = 0; a8 = 0; b8 = 0; sm8 = 0; out_ready8 = 1; exp_next8 = 0;
    in_valid4 = 0; a4 = 0; b4 = 0; sm4 = 0; out_ready4 = 1;
    acc8 = 0; acc4 = 0; lat8_done = 0; lat4_done = 0; acc_cyc8 = 0; n_acc8 = 0;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
    vecs[2]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[3]  = '{8'h80, 8'h7F, 1'b1, 16'hC080};
    vecs[4]  = '{8'h12, 8'h34, 1'b0, 16'h03A8};
    vecs[5]  = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
    vecs[6]  = '{8'h00, 8'hAB, 1'b0, 16'h0000};
    vecs[7]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
    vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[9]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    vecs[10] = '{8'h01, 8'h80, 1'b1, 16'hFF80};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready8), 0);
    chk("rst_out_valid", 32'(out_valid8), 0);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_p", 32'(p8), 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready8), 1);

    // Table-driven single products
    for (int i = 0; i < 11; i++) begin
      set8(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);
      in_valid8 = 1; out_ready8 = 1;
      wait_acc8();
      in_valid8 = 0;
      drain8();
      chk("idle_busy", 32'(busy8), 0);
      chk("idle_out_valid", 32'(out_valid8), 0);
      chk("idle_in_ready", 32'(in_ready8), 1);
    end

    // Back-to-back stream
    out_ready8 = 1; in_valid8 = 1;
    set8(8'h12, 8'h34, 1'b0, 16'h03A8);
    wait_acc8();
    c0 = acc_cyc8;
    set8(8'hFF, 8'h01, 1'b0, 16'h00FF);
    wait_acc8();
    chk("b2b_gap1", acc_cyc8 - c0, 5);
    set8(8'h00, 8'hAB, 1'b0, 16'h0000);
    wait_acc8();
    chk("b2b_gap2", acc_cyc8 - c0, 10);
    in_valid8 = 0;
    drain8();

    // Backpressure with a pending request
    out_ready8 = 0; in_valid8 = 1;
    set8(8'h03, 8'h05, 1'b0, 16'h000F);
    wait_acc8();
    set8(8'hC3, 8'h5A, 1'b1, 16'hEA8E);
    n = 0;
    while (!out_valid8 && n < 20) begin tick(); n++; end
    if (!out_valid8) fail_now("bp_out_valid_timeout");
    na = n_acc8;
    repeat (5) begin
      tick();
      chk("bp_out_valid", 32'(out_valid8), 1);
      chk("bp_in_ready", 32'(in_ready8), 0);
      chk("bp_busy", 32'(busy8), 0);
      chk("bp_p", 32'(p8), 32'h000F);
    end
    chk("bp_no_accept", n_acc8 - na, 0);
    out_ready8 = 1;
    acc8 = 0;
    tick();
    chk("bp_handoff_accept", 32'(acc8), 1);
    chk("bp_busy_after", 32'(busy8), 1);
    in_valid8 = 0;
    drain8();

    // Asynchronous reset two cycles into BUSY
    set8(8'h55, 8'h66, 1'b0, 16'h21DE);
    in_valid8 = 1; out_ready8 = 1;
    wait_acc8();
    in_valid8 = 0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("rm_out_valid", 32'(out_valid8), 0);
    chk("rm_busy", 32'(busy8), 0);
    chk("rm_p", 32'(p8), 0);
    chk("rm_in_ready", 32'(in_ready8), 0);
    q8.delete(); lat8_done = 0;
    q4.delete(); lat4_done = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rm_rel_in_ready", 32'(in_ready8), 1);
    chk("rm_rel_busy", 32'(busy8), 0);
    in_valid8 = 1;
    wait_acc8();
    in_valid8 = 0;
    drain8();

    // WIDTH=4 exhaustive, unsigned then signed, streamed back-to-back
    out_ready4 = 1; in_valid4 = 1;
    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0]; b4 = i[7:4]; sm4 = i[8];
      wait_acc4();
    end
    in_valid4 = 0;
    drain4();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vedic_mult_seq.md
# vedic_mult_seq

Parametrised, multi-cycle Vedic (Urdhva-Tiryagbhyam) multiplier, the next generation of the fixed 4-bit combinational Vedic multiplier in the ALU datapath. It takes WIDTH-bit operands under a valid/ready handshake, with optional two's-complement mode. It consumes the multiplier operand one 2-bit digit per cycle, forming each digit's row from WIDTH/2 2x2 Vedic cells, and accumulates the shifted rows. It returns a registered 2*WIDTH-bit product under a valid/ready handshake, so the ALU can issue multiplies without a long combinational path.

## Interface
- WIDTH, 8: operand width. Must be even and >= 4; other values are a elaboration error.
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operands a, b, signed_mode valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier, consumed 2 bits per cycle, LSB digit first
- signed_mode  in  1  1 = a, b, p are two's complement; 0 = unsigned
- out_valid  out  1  p holds a completed product
- out_ready  in  1  consumer accepts p this cycle
- p  out  2*WIDTH  product
- busy  out  1  high in BUSY state

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- in_ready = (IDLE) or (DONE and out_ready). busy = (BUSY). out_valid = (DONE).
- **Accept** (in_valid and in_ready at an edge):
  - Capture |a| and |b| as WIDTH-bit magnitudes and neg = signed_mode and (a[MSB] xor b[MSB]). In unsigned mode magnitudes are the raw operands.
  - Clear the accumulator and the digit counter; go to BUSY.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which is representable unsigned.
- **BUSY, digit i = 0..WIDTH/2-1:**
  - row = |a| x |b|[2i+1:2i], built from WIDTH/2 2x2 Vedic cells (each cell: 4-bit result from an AND/half-adder network) summed at 2-bit offsets.
  - acc += row << 2i, with acc 2*WIDTH bits wide; no overflow is possible.
  - After the last digit: p <= neg ? -(acc_final) : acc_final, truncated to 2*WIDTH bits, then go to DONE.
- **DONE:**
  - p holds its value until out_ready.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: accept the new operands on the same edge and go to BUSY.
  - out_ready=0: stay in DONE; in_ready=0.
- in_valid in BUSY is ignored; in_ready=0 there.
- signed -2^(W-1) x -2^(W-1) = 2^(2W-2) is exact in 2W bits.
- Zero operands take the full latency; there is no early termination.
- p is not cleared on leaving DONE; it holds its last value until the next completion.

## Timing
- Reset (async assert, any state):
  - Outputs: in_ready=0 while rst is high, 1 after release; out_valid=0, busy=0, p=0.
  - Internal state: accumulator, counter and neg cleared; FSM to IDLE.
  - Reset mid-BUSY or in DONE abandons the operation; no result is produced.
- Accept at edge E0. The digit for i is accumulated at edge E(i+1). At edge E(WIDTH/2), p is registered and out_valid rises.
- Latency is WIDTH/2 cycles from accept to out_valid (WIDTH=8: 4 cycles; WIDTH=4: 2 cycles).
- Max throughput, with out_ready held high and in_valid held high: one product per WIDTH/2 + 1 cycles. The DONE cycle overlaps with the next accept.
- No combinational path from in_valid or a/b to any output. in_ready depends combinationally on out_ready.

## Test plan
- **Unsigned max:** WIDTH=8, signed_mode=0, a=0xFF, b=0xFF, out_ready=1.
  - Required: out_valid exactly 4 cycles after accept, p=0xFE01, then IDLE.
- **Signed mixed and extreme:** WIDTH=8, signed_mode=1.
  - a=0xFD (-3), b=0x05: p=0xFFF1 (-15).
  - a=0x80, b=0x80: p=0x4000.
  - a=0x80, b=0x7F: p=0xC080.
- **Backpressure:** complete a product with out_ready=0 for 5 cycles while in_valid=1.
  - Required: p and out_valid stable, in_ready=0, busy=0, no new accept.
  - Release out_ready with in_valid still 1: hand-off and new accept occur on the same edge.
- **Back-to-back:** stream 0x12x0x34, 0xFFx0x01, 0x00x0xAB with in_valid and out_ready held high.
  - Required: p = 0x03A8, 0x00FF, 0x0000 at cycles 4, 9, 14 after the first accept.
- **Reset mid-operation:** assert rst 2 cycles into BUSY, asynchronous to clk.
  - Required: immediately out_valid=0, busy=0, p=0, in_ready=0.
  - After release: in_ready=1 and the next product is correct.
- **WIDTH=4 exhaustive:** all 256 unsigned and 256 signed operand pairs.
  - Required: p matches reference arithmetic (e.g. 0xF x 0xF = 0xE1 unsigned, 0x01 signed).
  - Latency 2 for every pair.
